// File: rtl/maverickOne_pkg.sv
// Project-wide constants shared by the maverickOne core.
package maverickOne_pkg;
   localparam int unsigned XLEN = 32;
endpackage

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC and issues in-order fetches.
// Tracks in-flight fetches in a circular queue and returns instructions to decode.
module fetch_pc_unit #(
   parameter int unsigned     XLEN     = maverickOne_pkg::XLEN,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic [XLEN-1:0] btb_pc_o,
   input  logic            btb_found_i,
   input  logic [XLEN-1:0] btb_next_pc_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_valid_o,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_req_ready_i,
   input  logic            imem_rsp_valid_i,
   input  logic [31:0]     imem_rsp_data_i,
   output logic            instr_valid_o,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   input  logic            instr_ready_i
);

   localparam int unsigned     AW      = $clog2(DEPTH);
   localparam int unsigned     CW      = AW + 1;
   localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [31:0]     data_mem [DEPTH];
   logic [DEPTH-1:0] has_data_q;
   logic [DEPTH-1:0] kill_q;
   logic [AW-1:0]   head_q;
   logic [AW-1:0]   tail_q;
   logic [AW-1:0]   rsp_q;
   logic [CW-1:0]   count_q;

   logic [DEPTH-1:0] occupied;
   logic             head_valid;
   logic             req_fire;
   logic             rsp_pending;
   logic             rsp_fire;
   logic             pop;

   // An entry is occupied when its distance from head is below the count.
   always_comb begin
      occupied = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         occupied[i] = ({1'b0, AW'(i) - head_q} < count_q);
      end
   end

   assign head_valid       = (count_q != '0);
   assign imem_req_valid_o = (count_q < CW'(DEPTH)) & ~redirect_i;
   assign req_fire         = imem_req_valid_o & imem_req_ready_i;
   assign rsp_pending      = occupied[rsp_q] & ~has_data_q[rsp_q];
   assign rsp_fire         = imem_rsp_valid_i & rsp_pending;

   assign btb_pc_o        = pc_q;
   assign imem_req_addr_o = pc_q;
   assign instr_valid_o   = head_valid & has_data_q[head_q] & ~kill_q[head_q] & ~redirect_i;
   assign instr_o         = head_valid ? data_mem[head_q] : '0;
   assign instr_pc_o      = head_valid ? pc_mem[head_q] : '0;

   // Killed entries drain silently once their response has landed.
   assign pop = head_valid & has_data_q[head_q] &
                (kill_q[head_q] | (instr_valid_o & instr_ready_i));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q       <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         rsp_q      <= '0;
         count_q    <= '0;
         has_data_q <= '0;
         kill_q     <= '0;
      end else begin
         if (redirect_i) begin
            pc_q <= redirect_pc_i & PC_MASK;
         end else if (req_fire) begin
            pc_q <= btb_found_i ? (btb_next_pc_i & PC_MASK) : pc_q + XLEN'(4);
         end
         if (req_fire) begin
            has_data_q[tail_q] <= 1'b0;
            kill_q[tail_q]     <= 1'b0;
            tail_q             <= tail_q + AW'(1);
         end
         if (rsp_fire) begin
            has_data_q[rsp_q] <= 1'b1;
            rsp_q             <= rsp_q + AW'(1);
         end
         if (redirect_i) begin
            kill_q <= kill_q | occupied;
         end
         if (pop) begin
            head_q <= head_q + AW'(1);
         end
         unique case ({req_fire, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (req_fire) pc_mem[tail_q]  <= pc_q;
      if (rsp_fire) data_mem[rsp_q] <= imem_rsp_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && imem_rsp_valid_i) begin
         assert (rsp_pending);
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic against
// a queue-level reference model and an in-order latency memory model.
module tb_fetch_pc_unit;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RST_PC = 32'h0000_1000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] btb_pc_o;
   logic        btb_found_i = 1'b0;
   logic [31:0] btb_next_pc_i = '0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_valid_o;
   logic [31:0] imem_req_addr_o;
   logic        imem_req_ready_i = 1'b0;
   logic        imem_rsp_valid_i = 1'b0;
   logic [31:0] imem_rsp_data_i = '0;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i = 1'b0;

   always #5 clk_i = ~clk_i;

   fetch_pc_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .btb_pc_o        (btb_pc_o),
      .btb_found_i     (btb_found_i),
      .btb_next_pc_i   (btb_next_pc_i),
      .redirect_i      (redirect_i),
      .redirect_pc_i   (redirect_pc_i),
      .imem_req_valid_o(imem_req_valid_o),
      .imem_req_addr_o (imem_req_addr_o),
      .imem_req_ready_i(imem_req_ready_i),
      .imem_rsp_valid_i(imem_rsp_valid_i),
      .imem_rsp_data_i (imem_rsp_data_i),
      .instr_valid_o   (instr_valid_o),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .instr_ready_i   (instr_ready_i)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      bit          has_data;
      bit          kill;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } req_t;

   ent_t        mq[$];
   req_t        mem[$];
   logic [31:0] m_pc = RST_PC;
   int unsigned cyc = 0;
   int unsigned last_due = 0;
   int unsigned lat = 1;
   int unsigned checks = 0;
   int unsigned failures = 0;
   logic [31:0] req_log[$];
   logic [31:0] ins_log[$];

   function automatic logic [31:0] mkdata(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_0F96 ^ (a * 32'd7);
   endfunction

   function automatic logic [31:0] at(input logic [31:0] q[$], input int unsigned i);
      return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive memory response, compare at negedge, advance model.
   task automatic step();
      bit          mv_req, mv_ins, acc, pop;
      int          k;
      int unsigned due;
      if (!rst_i && mem.size() > 0 && mem[0].due <= cyc) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = mkdata(mem[0].addr);
      end else begin
         imem_rsp_valid_i = 1'b0;
         imem_rsp_data_i  = $urandom;
      end
      @(negedge clk_i);
      if (rst_i) begin
         mq.delete();
         mem.delete();
         m_pc     = RST_PC;
         last_due = 0;
      end else begin
         mv_req = (mq.size() < DEPTH) && !redirect_i;
         mv_ins = (mq.size() > 0) && mq[0].has_data && !mq[0].kill && !redirect_i;
         check("btb_pc", 64'(btb_pc_o), 64'(m_pc));
         check("req_addr", 64'(imem_req_addr_o), 64'(m_pc));
         check("req_valid", 64'(imem_req_valid_o), 64'(mv_req));
         check("instr_valid", 64'(instr_valid_o), 64'(mv_ins));
         if (mq.size() == 0) begin
            check("instr_empty", 64'(instr_o), 64'd0);
            check("instr_pc_empty", 64'(instr_pc_o), 64'd0);
         end else if (mv_ins) begin
            check("instr", 64'(instr_o), 64'(mq[0].data));
            check("instr_pc", 64'(instr_pc_o), 64'(mq[0].pc));
         end
         if (imem_req_valid_o && imem_req_ready_i) req_log.push_back(imem_req_addr_o);
         if (instr_valid_o && instr_ready_i) ins_log.push_back(instr_pc_o);

         acc = mv_req && imem_req_ready_i;
         pop = (mq.size() > 0) && mq[0].has_data && (mq[0].kill || (mv_ins && instr_ready_i));
         if (redirect_i) foreach (mq[i]) mq[i].kill = 1'b1;
         if (imem_rsp_valid_i) begin
            k = -1;
            foreach (mq[i]) if (k < 0 && !mq[i].has_data) k = i;
            check("rsp_target", 64'(k >= 0), 64'd1);
            if (k >= 0) begin
               mq[k].data     = imem_rsp_data_i;
               mq[k].has_data = 1'b1;
            end
            void'(mem.pop_front());
         end
         if (pop) void'(mq.pop_front());
         if (acc) begin
            mq.push_back('{pc: m_pc, data: 32'd0, has_data: 1'b0, kill: 1'b0});
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            mem.push_back('{addr: m_pc, due: due});
            last_due = due;
         end
         if (redirect_i) m_pc = redirect_pc_i & ~32'h3;
         else if (acc) m_pc = btb_found_i ? (btb_next_pc_i & ~32'h3) : m_pc + 32'd4;
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_i       = 1'b1;
      redirect_i  = 1'b0;
      btb_found_i = 1'b0;
      step();
      step();
      rst_i = 1'b0;
      req_log.delete();
      ins_log.delete();
   endtask

   int unsigned stale;

   initial begin
      #1;
      // Reset and straight-line fetch
      imem_req_ready_i = 1'b1;
      instr_ready_i    = 1'b1;
      lat              = 1;
      do_reset();
      check("rst_btb_pc", 64'(btb_pc_o), 64'h1000);
      check("rst_req_valid", 64'(imem_req_valid_o), 64'd1);
      check("rst_instr_valid", 64'(instr_valid_o), 64'd0);
      check("rst_instr", 64'(instr_o), 64'd0);
      check("rst_instr_pc", 64'(instr_pc_o), 64'd0);
      repeat (6) step();
      check("seq_req0", 64'(at(req_log, 0)), 64'h1000);
      check("seq_req1", 64'(at(req_log, 1)), 64'h1004);
      check("seq_req2", 64'(at(req_log, 2)), 64'h1008);
      check("seq_ins0", 64'(at(ins_log, 0)), 64'h1000);
      check("seq_ins1", 64'(at(ins_log, 1)), 64'h1004);
      check("seq_ins2", 64'(at(ins_log, 2)), 64'h1008);

      // BTB hit at 0x1004 -> 0x2000
      do_reset();
      btb_next_pc_i = 32'h2000;
      repeat (8) begin
         btb_found_i = (m_pc == 32'h1004);
         step();
      end
      btb_found_i = 1'b0;
      check("btb_req2", 64'(at(req_log, 2)), 64'h2000);
      check("btb_ins0", 64'(at(ins_log, 0)), 64'h1000);
      check("btb_ins1", 64'(at(ins_log, 1)), 64'h1004);
      check("btb_ins2", 64'(at(ins_log, 2)), 64'h2000);

      // Decode stalled: queue fills, then one release frees one slot
      instr_ready_i = 1'b0;
      do_reset();
      repeat (8) step();
      check("full_accepts", 64'(req_log.size()), 64'd4);
      check("full_req_valid", 64'(imem_req_valid_o), 64'd0);
      instr_ready_i = 1'b1;
      step();
      instr_ready_i = 1'b0;
      step();
      step();
      check("full_one_out", 64'(ins_log.size()), 64'd1);
      check("full_out_pc", 64'(at(ins_log, 0)), 64'h1000);
      check("full_one_more", 64'(req_log.size()), 64'd5);

      // Redirect with requests in flight and one buffered response
      lat = 2;
      do_reset();
      repeat (3) step();
      ins_log.delete();
      instr_ready_i = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h3000;
      step();
      redirect_i = 1'b0;
      repeat (20) step();
      stale = 0;
      foreach (ins_log[i]) if (ins_log[i] < 32'h3000) stale++;
      check("redir_first", 64'(at(ins_log, 0)), 64'h3000);
      check("redir_stale", 64'(stale), 64'd0);

      // Back-to-back redirects with latency 3
      lat = 3;
      do_reset();
      repeat (4) step();
      ins_log.delete();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h4000;
      step();
      redirect_pc_i = 32'h5002;
      step();
      redirect_i = 1'b0;
      repeat (25) step();
      stale = 0;
      foreach (ins_log[i]) if (ins_log[i] < 32'h5000) stale++;
      check("redir2_first", 64'(at(ins_log, 0)), 64'h5000);
      check("redir2_stale", 64'(stale), 64'd0);

      // Reset mid-stream with two requests outstanding
      do_reset();
      repeat (2) step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check("mid_rst_addr", 64'(imem_req_addr_o), 64'h1000);
      check("mid_rst_req_valid", 64'(imem_req_valid_o), 64'd1);
      check("mid_rst_instr_valid", 64'(instr_valid_o), 64'd0);
      check("mid_rst_count", 64'(dut.count_q), 64'd0);

      // Randomized traffic
      for (int unsigned n = 0; n < 4000; n++) begin
         rst_i            = ($urandom_range(0, 299) == 0);
         redirect_i       = ($urandom_range(0, 11) == 0);
         redirect_pc_i    = $urandom;
         btb_found_i      = ($urandom_range(0, 3) == 0);
         btb_next_pc_i    = $urandom;
         imem_req_ready_i = ($urandom_range(0, 3) != 0);
         instr_ready_i    = ($urandom_range(0, 2) != 0);
         lat              = $urandom_range(1, 4);
         step();
      end
      rst_i = 1'b0;
      redirect_i = 1'b0;
      repeat (10) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
